// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared FSM state type and index helper for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arbState_t;

    // Explicit wrap so non-power-of-2 requester counts stay in range
    function automatic int wrapInc(int idx, int NumReq);
        return (idx == NumReq - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and FIFO write-port signals of the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32
);
    localparam int IW = $clog2(NumReq);

    logic [NumReq-1:0]                reqValid;
    logic [NumReq-1:0][DataWidth-1:0] reqData;
    logic [NumReq-1:0]                reqReady;
    logic                             fifoFull;
    logic                             fifoWriteEn;
    logic [DataWidth-1:0]             fifoWriteData;
    logic [IW-1:0]                    grantIdx;
    logic                             busy;

    modport master (
        output reqValid, reqData, fifoFull,
        input  reqReady, fifoWriteEn, fifoWriteData, grantIdx, busy
    );

    modport slave (
        input  reqValid, reqData, fifoFull,
        output reqReady, fifoWriteEn, fifoWriteData, grantIdx, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set bit at or above ptr
module rr_pick #(
    parameter int NumReq = 4,
    localparam int IW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic              found,
    output logic [IW-1:0]     idx
);

    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int k);
        return IW'((int'(p) + k) % NumReq);
    endfunction

    assign found = |req;

    // Scan farthest offset first so the nearest requester overwrites it
    always_comb begin
        idx = '0;
        for (int k = NumReq - 1; k >= 0; k--)
            idx = req[rot(ptr, k)] ? rot(ptr, k) : idx;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-limited arbiter in front of a FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IW = $clog2(NumReq);
    localparam int CW = $clog2(MaxBurst + 1);

    arbState_t     state_q, state_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d, rr_ptr_q, rr_ptr_d, pick_idx;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          found, beat, last_beat, quiet;

    rr_pick #(.NumReq(NumReq)) u_pick (
        .req   (bus.reqValid),
        .ptr   (rr_ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // A full FIFO freezes the grant: no beat, no count, no quiet exit
    assign beat      = state_q == ARB_GRANT && bus.reqValid[grant_idx_q] && !bus.fifoFull;
    assign last_beat = beat && beat_cnt_q == CW'(MaxBurst - 1);
    assign quiet     = !bus.reqValid[grant_idx_q] && !bus.fifoFull;

    assign bus.fifoWriteEn   = beat;
    assign bus.fifoWriteData = bus.reqData[grant_idx_q];
    assign bus.grantIdx      = grant_idx_q;
    assign bus.busy          = state_q == ARB_GRANT;
    assign bus.reqReady      = (state_q == ARB_GRANT && !bus.fifoFull)
                             ? NumReq'(1) << grant_idx_q : '0;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        if (state_q == ARB_IDLE) begin
            state_d     = found ? ARB_GRANT : ARB_IDLE;
            grant_idx_d = found ? pick_idx : grant_idx_q;
            beat_cnt_d  = found ? '0 : beat_cnt_q;
        end else begin
            beat_cnt_d = beat ? beat_cnt_q + 1'b1 : beat_cnt_q;
            state_d    = (last_beat || quiet) ? ARB_IDLE : ARB_GRANT;
            rr_ptr_d   = (last_beat || quiet) ? IW'(wrapInc(int'(grant_idx_q), NumReq)) : rr_ptr_q;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus checked every cycle against a behavioural arbiter model
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NumReq(N), .DataWidth(DW)) bus ();

    fifo_wr_arbiter #(.NumReq(N), .DataWidth(DW), .MaxBurst(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Producers: requester i offers words i*65536 + sent[i] while enabled and below its limit
    logic [N-1:0] en = '0;
    int           sent [N];
    int           lim  [N];
    logic [N-1:0] fire = '0;

    // Everything the FIFO received, with the cycle number it was written in
    logic [DW-1:0] log_d [$];
    int            log_c [$];
    int            cyc_n = 0;

    // Model state: owner -1 means idle
    int           m_owner = -1;
    int           m_gidx  = 0;
    int           m_nxt   = 0;
    int           m_cnt   = 0;
    logic [N-1:0] exp_ready;
    logic         exp_we;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.reqValid[i] = en[i] && sent[i] < lim[i];
            bus.reqData[i]  = 32'(i * 65536 + sent[i]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (fire[i]) sent[i]++;
            drive();
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int b = 0;
        while (log_d.size() < n && b < budget) begin
            cyc(1);
            b++;
        end
        chk({name, "_timeout"}, int'(log_d.size() >= n), 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    // Compare process: outputs must equal what the arbitration rules dictate this cycle
    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (rst) begin
            m_owner = -1;
            m_gidx  = 0;
            m_nxt   = 0;
            m_cnt   = 0;
        end
        exp_we    = (m_owner >= 0) ? (bus.reqValid[m_owner] && !bus.fifoFull) : 1'b0;
        exp_ready = (m_owner >= 0 && !bus.fifoFull) ? N'(1 << m_owner) : '0;
        chk("ready", int'(bus.reqReady), int'(exp_ready));
        chk("write_en", int'(bus.fifoWriteEn), int'(exp_we));
        chk("busy", int'(bus.busy), int'(m_owner >= 0));
        chk("grant_idx", int'(bus.grantIdx), m_gidx);
        chk("ready_onehot", int'($countones(bus.reqReady) <= 1), 1);
        if (m_owner >= 0)
            chk("write_data", int'(bus.fifoWriteData), int'(bus.reqData[m_owner]));
        fire = bus.reqReady & bus.reqValid;
        if (bus.fifoWriteEn && !rst) begin
            log_d.push_back(bus.fifoWriteData);
            log_c.push_back(cyc_n);
        end
        if (!rst) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_nxt + k) % N;
                    if (m_owner < 0 && bus.reqValid[c]) begin
                        m_owner = c;
                        m_gidx  = c;
                        m_cnt   = 0;
                    end
                end
            end else begin
                if (exp_we) m_cnt++;
                if ((exp_we && m_cnt == MB) || (!bus.reqValid[m_owner] && !bus.fifoFull)) begin
                    m_nxt   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int base2;
        int off2 [10] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
        int off4 [6]  = '{0, 1, 5, 6, 8, 9};
        int off5 [5]  = '{0, 1, 4, 5, 6};
        int own5 [5]  = '{3, 3, 0, 0, 0};
        int low5 [5]  = '{0, 1, 0, 1, 2};
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            lim[i]  = 0;
        end
        bus.fifoFull = 1'b0;
        drive();
        cyc(2);
        rst = 1'b0;

        // Reset then idle for 10 cycles
        cyc(10);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_we", int'(bus.fifoWriteEn), 0);
        chk("idle_ready", int'(bus.reqReady), 0);
        chk("idle_grant", int'(bus.grantIdx), 0);
        chk("idle_nowrites", log_d.size(), 0);

        // Single requester 2, ten words: bursts 4,4,2 with one-cycle gaps
        base   = log_d.size();
        lim[2] = 10;
        en     = 4'b0100;
        drive();
        wait_writes(base + 10, 40, "single");
        cyc(3);
        chk("single_count", log_d.size() - base, 10);
        for (int k = 0; k < 10; k++) begin
            chk("single_data", int'(log_d[base + k]), 2 * 65536 + k);
            chk("single_cycle", log_c[base + k] - log_c[base], off2[k]);
        end
        chk("single_grant", int'(bus.grantIdx), 2);

        // All four continuously valid from a fresh reset: 0,1,2,3,0,... four beats each
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            lim[i]  = 1000;
        end
        base = log_d.size();
        en   = 4'b1111;
        drive();
        wait_writes(base + 32, 100, "allvalid");
        en = '0;
        drive();
        cyc(3);
        for (int k = 0; k < 32; k++) begin
            chk("rr_owner", int'(log_d[base + k] >> 16), (k / 4) % 4);
            chk("rr_word", int'(log_d[base + k] & 32'hffff), (k / 16) * 4 + k % 4);
        end

        // FIFO full for three cycles after two beats of requester 1
        sent[1] = 0;
        lim[1]  = 6;
        en      = 4'b0010;
        base    = log_d.size();
        drive();
        wait_writes(base + 2, 20, "full_pre");
        bus.fifoFull = 1'b1;
        repeat (3) begin
            #1;
            chk("full_we", int'(bus.fifoWriteEn), 0);
            chk("full_ready1", int'(bus.reqReady[1]), 0);
            chk("full_busy", int'(bus.busy), 1);
            cyc(1);
        end
        bus.fifoFull = 1'b0;
        wait_writes(base + 6, 30, "full_post");
        cyc(3);
        chk("full_count", log_d.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            chk("full_data", int'(log_d[base + k]), 65536 + k);
            chk("full_cycle", log_c[base + k] - log_c[base], off4[k]);
        end

        // Requester 3 goes quiet after two beats; pointer wraps so pending requester 0 wins
        sent[0] = 0;
        sent[3] = 0;
        lim[0]  = 3;
        lim[3]  = 2;
        en      = 4'b1001;
        base    = log_d.size();
        drive();
        wait_writes(base + 5, 40, "quiet");
        cyc(3);
        chk("quiet_count", log_d.size() - base, 5);
        for (int k = 0; k < 5; k++) begin
            chk("quiet_owner", int'(log_d[base + k] >> 16), own5[k]);
            chk("quiet_word", int'(log_d[base + k] & 32'hffff), low5[k]);
            chk("quiet_cycle", log_c[base + k] - log_c[base], off5[k]);
        end
        chk("quiet_grant", int'(bus.grantIdx), 0);

        // Reset during beat 3 of requester 1; the next grant restarts from index 0
        sent[1] = 0;
        lim[1]  = 1000;
        en      = 4'b0010;
        base    = log_d.size();
        drive();
        wait_writes(base + 2, 20, "midrst_pre");
        chk("midrst_inflight_we", int'(bus.fifoWriteEn), 1);
        rst = 1'b1;
        #1;
        chk("midrst_we", int'(bus.fifoWriteEn), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_ready", int'(bus.reqReady), 0);
        chk("midrst_grant", int'(bus.grantIdx), 0);
        sent[3] = 0;
        lim[3]  = 1000;
        en      = 4'b1010;
        drive();
        cyc(1);
        rst   = 1'b0;
        base2 = log_d.size();
        chk("midrst_dropped", base2 - base, 2);
        wait_writes(base2 + 1, 20, "midrst_post");
        if (log_d.size() > base2)
            chk("midrst_first_owner", int'(log_d[base2] >> 16), 1);
        en = '0;
        drive();
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
